// File: rtl/bench_sequencer_pkg.sv
// Shared types and helpers for the benchmark sequencer: engine opcodes,
// sweep FSM state encoding and a constant clog2 for width derivation.
package bench_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_XOR = 4'h3,
    OP_MUL = 4'h4
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_NEXT_OP,
    S_NEXT_COND,
    S_FINISH
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bench_sequencer_if.sv
// Sequencer-to-engine handshake: one start pulse with op/condition, one done
// pulse with the result.
interface bench_sequencer_if #(
  parameter int CW  = 2,
  parameter int OPW = 16,
  parameter int RW  = 32
);
  logic           start;
  logic [CW-1:0]  cond;
  logic [3:0]     opcode;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           done;
  logic [RW-1:0]  result;

  modport master (output start, cond, opcode, a, b, input done, result);
  modport slave  (input start, cond, opcode, a, b, output done, result);
endinterface

// File: rtl/bench_minsel.sv
// Combinational N-way minimum select returning a one-hot of the winning
// index; on equal values the lowest index wins.
module bench_minsel #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [W-1:0] vals [N],
  output logic [N-1:0] onehot
);

  always_comb begin
    logic [W-1:0] best_val;
    int           best_idx;
    // NOTE: every variable gets a value before any branch so no path can
    // leave it holding its old value, which would infer a latch.
    best_val = vals[0];
    best_idx = 0;
    onehot   = '0;
    for (int i = 1; i < N; i++) begin
      if (vals[i] < best_val) begin
        best_val = vals[i];
        best_idx = i;
      end
    end
    for (int i = 0; i < N; i++) onehot[i] = (i == best_idx);
  end

endmodule

// File: rtl/bench_sequencer.sv
// Runs a programmable op list through an external engine under each routing
// condition, accumulating per-condition cycle totals, checksums and error flags.
module bench_sequencer
  import bench_sequencer_pkg::*;
#(
  parameter int NUM_COND    = 4,
  parameter int MAX_OPS     = 16,
  parameter int OPW         = 16,
  parameter int RW          = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CW = clog2(NUM_COND),
  localparam int AW = clog2(MAX_OPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [3:0]          prog_op,
  input  logic [OPW-1:0]      prog_a,
  input  logic [OPW-1:0]      prog_b,
  input  logic [AW:0]         cfg_num_ops,
  input  logic                run,
  output logic                busy,
  output logic                done,
  bench_sequencer_if.master   eng,
  input  logic [CW-1:0]       rd_cond,
  output logic [CNT_W-1:0]    rd_time,
  output logic [RW-1:0]       rd_csum,
  output logic [NUM_COND-1:0] best_onehot,
  output logic [NUM_COND-1:0] err_timeout,
  output logic [NUM_COND-1:0] err_mismatch
);

  localparam int TW = clog2(TIMEOUT_CYC) + 1;

  logic [3:0]     tbl_op [MAX_OPS];
  logic [OPW-1:0] tbl_a  [MAX_OPS];
  logic [OPW-1:0] tbl_b  [MAX_OPS];

  state_t           state;
  logic [CW-1:0]    cond;
  logic [AW-1:0]    op;
  logic [AW:0]      num_ops;
  logic [AW:0]      num_ops_clamped;
  logic [TW-1:0]    wait_cnt;
  logic [CNT_W-1:0] acc  [NUM_COND];
  logic [RW-1:0]    csum [NUM_COND];

  // NOTE: the op table has no reset so it can map onto plain RAM; a program
  // loaded once survives any number of sweep resets.
  always_ff @(posedge clk) begin
    if (prog_we && !busy && (int'(prog_addr) < MAX_OPS)) begin
      tbl_op[prog_addr] <= prog_op;
      tbl_a[prog_addr]  <= prog_a;
      tbl_b[prog_addr]  <= prog_b;
    end
  end

  assign num_ops_clamped = (cfg_num_ops > (AW+1)'(MAX_OPS)) ? (AW+1)'(MAX_OPS) : cfg_num_ops;

  always_ff @(posedge clk) begin
    // NOTE: all state here updates with <= so every read sees the value from
    // before this edge, independent of statement order.
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      eng.start    <= 1'b0;
      eng.cond     <= '0;
      eng.opcode   <= '0;
      eng.a        <= '0;
      eng.b        <= '0;
      cond         <= '0;
      op           <= '0;
      num_ops      <= '0;
      wait_cnt     <= '0;
      err_timeout  <= '0;
      err_mismatch <= '0;
      for (int i = 0; i < NUM_COND; i++) begin
        acc[i]  <= '0;
        csum[i] <= '0;
      end
    end else begin
      done      <= 1'b0;
      eng.start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            num_ops      <= num_ops_clamped;
            cond         <= '0;
            op           <= '0;
            busy         <= 1'b1;
            err_timeout  <= '0;
            err_mismatch <= '0;
            for (int i = 0; i < NUM_COND; i++) begin
              acc[i]  <= '0;
              csum[i] <= '0;
            end
            state <= (num_ops_clamped == '0) ? S_FINISH : S_LOAD;
          end
        end
        // Operands and start are registered together so the engine sees them in START.
        S_LOAD: begin
          eng.cond   <= cond;
          eng.opcode <= tbl_op[op];
          eng.a      <= tbl_a[op];
          eng.b      <= tbl_b[op];
          eng.start  <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!(&acc[cond])) acc[cond] <= acc[cond] + 1'b1;
          if (eng.done) begin
            csum[cond] <= csum[cond] ^ eng.result;
            state      <= S_NEXT_OP;
          end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout[cond] <= 1'b1;
            state             <= S_NEXT_OP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_NEXT_OP: begin
          if ({1'b0, op} == num_ops - 1'b1) begin
            state <= S_NEXT_COND;
          end else begin
            op    <= op + 1'b1;
            state <= S_LOAD;
          end
        end
        S_NEXT_COND: begin
          if (cond != '0 && csum[cond] != csum[0]) err_mismatch[cond] <= 1'b1;
          if (cond == CW'(NUM_COND - 1)) begin
            state <= S_FINISH;
          end else begin
            cond  <= cond + 1'b1;
            op    <= '0;
            state <= S_LOAD;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_time = '0;
    rd_csum = '0;
    if (int'(rd_cond) < NUM_COND) begin
      rd_time = acc[rd_cond];
      rd_csum = csum[rd_cond];
    end
  end

  bench_minsel #(.N(NUM_COND), .W(CNT_W)) u_minsel (
    .vals   (acc),
    .onehot (best_onehot)
  );

endmodule

// File: doc/bench_sequencer.md
Name: bench_sequencer

Overview:
Parametrised benchmark sequencer. It runs a programmable list of up to MAX_OPS operations through an external execution engine under each of NUM_COND routing conditions, and accumulates per-condition cycle counts. It also accumulates a per-condition result checksum, flags timeouts and result mismatches, and reports the fastest condition as a one-hot vector. It sits between the board top level (LEDs/debug readout) and the router engine, and replaces the fixed 9-op, 4-condition benchmark with a run/done-controlled, reprogrammable one.

Parameters:
NUM_COND, 4, number of conditions swept (2..8); condition index width CW = clog2(NUM_COND)
MAX_OPS, 16, op table depth (2..64); address width AW = clog2(MAX_OPS)
OPW, 16, operand width
RW, 32, engine result width
CNT_W, 32, cycle counter width
TIMEOUT_CYC, 1024, max wait cycles per op before abort of that op

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
prog_we  in  1  op table write strobe; ignored while busy
prog_addr  in  AW  op table write address
prog_op  in  4  opcode to store
prog_a  in  OPW  operand A to store
prog_b  in  OPW  operand B to store
cfg_num_ops  in  AW+1  ops per condition; sampled on run
run  in  1  start pulse; ignored while busy
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
eng_start  out  1  one-cycle start to engine
eng_cond  out  CW  condition select
eng_opcode  out  4  opcode to engine
eng_a  out  OPW  operand A to engine
eng_b  out  OPW  operand B to engine
eng_done  in  1  engine completion pulse
eng_result  in  RW  engine result, valid with eng_done
rd_cond  in  CW  readout select
rd_time  out  CNT_W  cycle total of condition rd_cond (combinational read)
rd_csum  out  RW  XOR checksum of condition rd_cond
best_onehot  out  NUM_COND  fastest condition
err_timeout  out  NUM_COND  per-condition timeout flag
err_mismatch  out  NUM_COND  checksum differs from condition 0 (bit 0 always 0)

Behaviour:
- Reset (rst_n=0 at clk edge) clears: all times, checksums and error flags; busy=0, done=0, eng_start=0, eng_cond/opcode/a/b=0; state IDLE. best_onehot=1 (cond0). The op table is not cleared. Reset mid-sweep aborts immediately; a later eng_done is ignored.
- States: IDLE, LOAD, START, WAIT, NEXT_OP, NEXT_COND, FINISH.
- IDLE: on run, latch N = cfg_num_ops (values > MAX_OPS clamp to MAX_OPS), clear times/checksums/flags, set busy=1, cond=0, op=0, go to LOAD. If N=0, go straight to FINISH.
- LOAD: drive eng_opcode/a/b from table[op] and eng_cond=cond; go to START.
- START: eng_start=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT:
  - acc[cond] += 1 every cycle, including the cycle eng_done is seen. An engine asserting done L cycles after eng_start therefore adds exactly L.
  - On eng_done: csum[cond] ^= eng_result; go to NEXT_OP.
  - If the wait counter reaches TIMEOUT_CYC without eng_done: set err_timeout[cond], leave csum unchanged, go to NEXT_OP. That op contributes exactly TIMEOUT_CYC.
  - eng_done outside WAIT is ignored.
- NEXT_OP: if op == N-1, go to NEXT_COND; else op += 1 and go to LOAD.
- NEXT_COND: if cond != 0 and csum[cond] != csum[0], set err_mismatch[cond]. If cond == NUM_COND-1, go to FINISH; else cond += 1, op=0, go to LOAD.
- FINISH: pulse done for one cycle, busy=0, return to IDLE. Results hold until the next run or reset.
- Accumulators saturate at all-ones and do not wrap.
- best_onehot: combinational minimum over the times; on a tie the lowest index wins. Valid once done has pulsed.
- prog_we writing while busy=1 is dropped. A write and a run in the same IDLE cycle: the write lands first, and the run uses the new table.

Decomposition:
- Shared package/header: opcode defines (existing), state encodings, and a clog2 constant function.
- One sub-module, bench_minsel: parametrised NUM_COND-way minimum/argmin to one-hot with lowest-index tie-break, purely combinational.

Test Plan:
- Engine model with latency 1 on cond0 and 6 on cond1–3; 9 ops programmed; run -> rd_time = 9, 54, 54, 54; best_onehot = 0001; done pulses once; eng_start pulses = 36.
- Latencies 5, 3, 3, 7 -> times 45, 27, 27, 63; best_onehot = 0010 (tie-break to lowest index).
- TIMEOUT_CYC = 64; engine never answers cond2 op3; others latency 2 -> cond2 time = 8·2 + 64 = 80; err_timeout = 0100; sweep still completes.
- Engine returns a+b for all conditions except cond3, which returns a+b+1 on one op -> err_mismatch = 1000; rd_csum(0) = rd_csum(1).
- Drop rst_n during cond1 WAIT -> next cycle busy=0, times 0, eng_start=0; a following run with cfg_num_ops = 0 -> done pulses 2 cycles after run with all times 0.
- run and prog_we asserted while busy -> no restart and table unchanged (verified by the next sweep's results).
